// File: rtl/vend_pkg.sv
// Shared state type, seven-segment digit constants and BCD helpers for vend_ctrl.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, WAIT_TAKE} state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_F     = 7'b000_1110;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Up to eight decimal digits; digit 0 lands in bits [3:0].
  function automatic logic [31:0] bin2bcd(input logic [31:0] value, input int digits);
    logic [31:0] bcd;
    logic [31:0] rem;
    bcd = '0;
    rem = value;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) begin
        bcd[4*i +: 4] = 4'(rem % 32'd10);
        rem = rem / 32'd10;
      end
    end
    return bcd;
  endfunction

  function automatic logic [6:0] bcd2seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises one active-low key and emits a one-cycle press pulse once the key has
// been stably low for DEB_CYCLES cycles after being stably high; releases are silent.
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          sync_prev;
  logic          level;
  logic [CW-1:0] cnt;

  // Everything resets "pressed" so a key held through reset must be released first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      level     <= 1'b0;
      cnt       <= CNT_LOAD;
      press     <= 1'b0;
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      sync_prev <= sync2;
      press     <= 1'b0;
      if (sync2 != sync_prev) begin
        cnt <= CNT_LOAD;
      end else if (cnt > CW'(1)) begin
        cnt <= cnt - CW'(1);
      end else begin
        level <= sync2;
        press <= level & ~sync2;
      end
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending front-panel controller: debounced keys drive a pay/price/change FSM whose
// totals are decoded combinationally onto active-low seven-segment digit vectors.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                    NUM_COIN     = 2,
  parameter logic [4*NUM_COIN-1:0] COIN_VAL     = {4'd5, 4'd1},
  parameter int                    ITEM_PRICE   = 3,
  parameter int                    DIGITS       = 2,
  parameter int                    DEB_CYCLES   = 1000000,
  parameter int                    TAKE_TIMEOUT = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_COIN-1:0]   coin_key,
  input  logic                  sel_key,
  input  logic                  ok_key,
  input  logic                  cancel_key,
  input  logic                  IRsig,
  output logic                  vend,
  output logic                  litup,
  output logic                  fault,
  output logic [7*DIGITS-1:0]   seg_pay,
  output logic [7*DIGITS-1:0]   seg_item,
  output logic [7*DIGITS-1:0]   seg_chg
);

  localparam int              MAX_INT = 10**DIGITS - 1;
  localparam int              W       = $clog2(MAX_INT + 1);
  localparam logic [W-1:0]    MAX_V   = W'(MAX_INT);
  localparam int              TW      = $clog2(TAKE_TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_V    = TW'(TAKE_TIMEOUT);
  localparam logic [3:0]      PRICE   = 4'(ITEM_PRICE);
  localparam int              BW      = 4 * DIGITS;

  logic [NUM_COIN-1:0] coin_ev;
  logic                sel_ev, ok_ev, cancel_ev;

  for (genvar i = 0; i < NUM_COIN; i++) begin : g_coin
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .rst_n(rst_n), .key_n(coin_key[i]), .press(coin_ev[i]));
  end
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk(clk), .rst_n(rst_n), .key_n(sel_key), .press(sel_ev));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
    .clk(clk), .rst_n(rst_n), .key_n(ok_key), .press(ok_ev));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cancel (
    .clk(clk), .rst_n(rst_n), .key_n(cancel_key), .press(cancel_ev));

  state_t          state, state_n;
  logic [W-1:0]    pay, pay_n, item, item_n, chg, chg_n;
  logic            pay_ovf, pay_ovf_n, item_ovf, item_ovf_n;
  logic            short_flag, short_n, fault_n;
  logic [TW-1:0]   timer, timer_n;
  logic            ir_s1, ir_s2;
  logic            do_cancel, do_ok, do_coin, do_sel, any_ev;
  logic [3:0]      coin_amt;
  logic [W:0]      pay_sum, item_sum;

  // Returns {saturated, value}.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [3:0] b);
    logic [W:0] s;
    s = {1'b0, a} + (W+1)'(b);
    if (s > {1'b0, MAX_V}) s = {1'b1, MAX_V};
    return s;
  endfunction

  // Priority cancel > ok > coin (lowest index) > sel; losers are dropped.
  always_comb begin
    coin_amt = '0;
    for (int i = NUM_COIN - 1; i >= 0; i--) begin
      if (coin_ev[i]) coin_amt = COIN_VAL[4*i +: 4];
    end
    do_cancel = cancel_ev;
    do_ok     = ok_ev & ~cancel_ev;
    do_coin   = (|coin_ev) & ~cancel_ev & ~ok_ev;
    do_sel    = sel_ev & ~(|coin_ev) & ~cancel_ev & ~ok_ev;
    any_ev    = cancel_ev | ok_ev | (|coin_ev) | sel_ev;
    pay_sum   = sat_add(pay, coin_amt);
    item_sum  = sat_add(item, PRICE);
  end

  always_comb begin
    state_n    = state;
    pay_n      = pay;
    item_n     = item;
    chg_n      = chg;
    pay_ovf_n  = pay_ovf;
    item_ovf_n = item_ovf;
    short_n    = short_flag;
    fault_n    = fault;
    timer_n    = timer;
    if (any_ev && state != WAIT_TAKE) begin
      short_n = 1'b0;
      fault_n = 1'b0;
    end
    case (state)
      IDLE: begin
        if (do_coin) begin
          chg_n     = '0;
          pay_n     = pay_sum[W-1:0];
          pay_ovf_n = pay_ovf | pay_sum[W];
          state_n   = COLLECT;
        end else if (do_sel) begin
          item_n     = item_sum[W-1:0];
          item_ovf_n = item_ovf | item_sum[W];
          state_n    = COLLECT;
        end
      end
      COLLECT: begin
        if (do_cancel) begin
          chg_n      = pay;
          pay_n      = '0;
          item_n     = '0;
          pay_ovf_n  = 1'b0;
          item_ovf_n = 1'b0;
          state_n    = IDLE;
        end else if (do_ok) begin
          if (item != '0 && pay >= item && !pay_ovf && !item_ovf) begin
            chg_n   = pay - item;
            pay_n   = '0;
            item_n  = '0;
            state_n = VEND;
          end else if (item == '0 || pay < item) begin
            short_n = 1'b1;
          end
        end else if (do_coin) begin
          pay_n     = pay_sum[W-1:0];
          pay_ovf_n = pay_ovf | pay_sum[W];
        end else if (do_sel) begin
          item_n     = item_sum[W-1:0];
          item_ovf_n = item_ovf | item_sum[W];
        end
      end
      VEND: begin
        timer_n = '0;
        state_n = WAIT_TAKE;
      end
      WAIT_TAKE: begin
        timer_n = timer + TW'(1);
        if (ir_s2) begin
          state_n = IDLE;
        end else if (timer_n == TO_V) begin
          fault_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pay        <= '0;
      item       <= '0;
      chg        <= '0;
      pay_ovf    <= 1'b0;
      item_ovf   <= 1'b0;
      short_flag <= 1'b0;
      fault      <= 1'b0;
      timer      <= '0;
      ir_s1      <= 1'b0;
      ir_s2      <= 1'b0;
      litup      <= 1'b0;
    end else begin
      state      <= state_n;
      pay        <= pay_n;
      item       <= item_n;
      chg        <= chg_n;
      pay_ovf    <= pay_ovf_n;
      item_ovf   <= item_ovf_n;
      short_flag <= short_n;
      fault      <= fault_n;
      timer      <= timer_n;
      ir_s1      <= IRsig;
      ir_s2      <= ir_s1;
      litup      <= ir_s2;
    end
  end

  assign vend = (state == VEND);

  logic [BW-1:0] pay_bcd, item_bcd, chg_bcd;

  always_comb begin
    pay_bcd  = BW'(bin2bcd(32'(pay), DIGITS));
    item_bcd = BW'(bin2bcd(32'(item), DIGITS));
    chg_bcd  = BW'(bin2bcd(32'(chg), DIGITS));
    seg_pay  = '1;
    seg_item = '1;
    seg_chg  = '1;
    for (int d = 0; d < DIGITS; d++) begin
      seg_pay[7*d +: 7]  = pay_ovf    ? SEG_F : bcd2seg(pay_bcd[4*d +: 4]);
      seg_item[7*d +: 7] = item_ovf   ? SEG_F : bcd2seg(item_bcd[4*d +: 4]);
      seg_chg[7*d +: 7]  = short_flag ? SEG_F : bcd2seg(chg_bcd[4*d +: 4]);
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with short debounce and take-out timeout.
module tb_vend_ctrl;
  import vend_pkg::*;

  localparam int DEB = 16;
  localparam int TO  = 200;

  localparam logic [6:0] S0 = 7'b100_0000;
  localparam logic [6:0] S1 = 7'b111_1001;
  localparam logic [6:0] S2 = 7'b010_0100;
  localparam logic [6:0] S3 = 7'b011_0000;
  localparam logic [6:0] S5 = 7'b001_0010;
  localparam logic [6:0] S6 = 7'b000_0010;
  localparam logic [6:0] S7 = 7'b111_1000;
  localparam logic [6:0] S9 = 7'b001_0000;
  localparam logic [6:0] SF = 7'b000_1110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  coin_key = 2'b11;
  logic        sel_key = 1'b1, ok_key = 1'b1, cancel_key = 1'b1, ir_sig = 1'b0;
  logic        vend, litup, fault;
  logic [13:0] seg_pay, seg_item, seg_chg;

  int n_cmp = 0;
  int n_bad = 0;
  int vend_cnt = 0;

  vend_ctrl #(
    .NUM_COIN(2), .COIN_VAL({4'd5, 4'd1}), .ITEM_PRICE(3), .DIGITS(2),
    .DEB_CYCLES(DEB), .TAKE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_key(coin_key), .sel_key(sel_key),
    .ok_key(ok_key), .cancel_key(cancel_key), .IRsig(ir_sig), .vend(vend),
    .litup(litup), .fault(fault), .seg_pay(seg_pay), .seg_item(seg_item),
    .seg_chg(seg_chg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (vend === 1'b1) vend_cnt++;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       coin_key[0] = v;
      1:       coin_key[1] = v;
      2:       sel_key = v;
      3:       ok_key = v;
      default: cancel_key = v;
    endcase
  endtask

  // k: 0/1 coin, 2 sel, 3 ok, 4 cancel
  task automatic press_key(input int k);
    @(negedge clk);
    set_key(k, 1'b0);
    cycles(DEB + 8);
    set_key(k, 1'b1);
    cycles(DEB + 8);
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    chk_val(tag, 32'(dut.state), 32'(exp));
  endtask

  initial begin
    cycles(3);
    chk_val("rst_seg_pay", 32'(seg_pay), 32'({S0, S0}));
    chk_val("rst_seg_item", 32'(seg_item), 32'({S0, S0}));
    chk_val("rst_seg_chg", 32'(seg_chg), 32'({S0, S0}));
    chk_val("rst_vend", 32'(vend), 32'd0);
    chk_val("rst_fault", 32'(fault), 32'd0);
    chk_val("rst_litup", 32'(litup), 32'd0);
    rst_n = 1'b1;
    cycles(30);

    // coin1 + two selects, then a short ok
    press_key(1);
    press_key(2);
    press_key(2);
    chk_val("t1_pay_05", 32'(seg_pay), 32'({S0, S5}));
    chk_val("t1_item_06", 32'(seg_item), 32'({S0, S6}));
    press_key(3);
    chk_val("t1_short_chg_ff", 32'(seg_chg), 32'({SF, SF}));
    chk_val("t1_no_vend", 32'(vend_cnt), 32'd0);
    chk_state("t1_state_collect", COLLECT);

    // top up with coin0 twice and vend
    press_key(0);
    press_key(0);
    chk_val("t2_pay_07", 32'(seg_pay), 32'({S0, S7}));
    chk_val("t2_short_cleared", 32'(seg_chg), 32'({S0, S0}));
    press_key(3);
    chk_val("t2_vend_one_cycle", 32'(vend_cnt), 32'd1);
    chk_val("t2_chg_01", 32'(seg_chg), 32'({S0, S1}));
    chk_val("t2_pay_00", 32'(seg_pay), 32'({S0, S0}));
    chk_val("t2_item_00", 32'(seg_item), 32'({S0, S0}));
    chk_state("t2_state_wait", WAIT_TAKE);
    ir_sig = 1'b1;
    cycles(5);
    chk_state("t2_taken_idle", IDLE);
    chk_val("t2_litup_on", 32'(litup), 32'd1);
    ir_sig = 1'b0;
    cycles(5);
    chk_val("t2_litup_off", 32'(litup), 32'd0);

    // pay saturation
    for (int i = 0; i < 20; i++) press_key(1);
    chk_val("t3_pay_ff", 32'(seg_pay), 32'({SF, SF}));
    chk_val("t3_chg_cleared", 32'(seg_chg), 32'({S0, S0}));
    press_key(3);
    chk_val("t3_ok_no_vend", 32'(vend_cnt), 32'd1);
    chk_state("t3_ok_stays", COLLECT);
    chk_val("t3_item0_short", 32'(seg_chg), 32'({SF, SF}));
    press_key(4);
    chk_val("t3_cancel_chg_99", 32'(seg_chg), 32'({S9, S9}));
    chk_val("t3_cancel_pay_00", 32'(seg_pay), 32'({S0, S0}));
    chk_state("t3_cancel_idle", IDLE);

    // simultaneous coin events: lowest index wins
    @(negedge clk);
    coin_key = 2'b00;
    cycles(DEB + 8);
    coin_key = 2'b11;
    cycles(DEB + 8);
    chk_val("t4_pay_01", 32'(seg_pay), 32'({S0, S1}));
    chk_val("t4_chg_cleared", 32'(seg_chg), 32'({S0, S0}));
    press_key(4);
    chk_val("t4_cancel_chg_01", 32'(seg_chg), 32'({S0, S1}));

    // glitchy hold on sel produces nothing
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sel_key = 1'b0;
      cycles(12);
      sel_key = 1'b1;
      cycles(5);
    end
    cycles(30);
    chk_val("t5_glitch_no_event", 32'(seg_item), 32'({S0, S0}));
    chk_state("t5_glitch_idle", IDLE);
    @(negedge clk);
    sel_key = 1'b0;
    cycles(DEB + 3);
    chk_val("t5_not_yet", 32'(seg_item), 32'({S0, S0}));
    cycles(1);
    chk_val("t5_on_time", 32'(seg_item), 32'({S0, S3}));
    cycles(20);
    sel_key = 1'b1;
    cycles(40);
    chk_val("t5_exactly_one", 32'(seg_item), 32'({S0, S3}));

    // take-out timeout
    press_key(1);
    press_key(3);
    chk_val("t6_vend", 32'(vend_cnt), 32'd2);
    chk_val("t6_chg_02", 32'(seg_chg), 32'({S0, S2}));
    cycles(100);
    chk_val("t6_fault_early", 32'(fault), 32'd0);
    chk_state("t6_still_wait", WAIT_TAKE);
    cycles(120);
    chk_val("t6_fault_set", 32'(fault), 32'd1);
    chk_state("t6_timeout_idle", IDLE);
    press_key(2);
    chk_val("t6_fault_cleared", 32'(fault), 32'd0);
    chk_state("t6_collect", COLLECT);

    // reset in WAIT_TAKE, with sel held through reset
    press_key(1);
    press_key(3);
    chk_state("t7_wait", WAIT_TAKE);
    cycles(20);
    sel_key = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_val("t7_rst_pay", 32'(seg_pay), 32'({S0, S0}));
    chk_val("t7_rst_item", 32'(seg_item), 32'({S0, S0}));
    chk_val("t7_rst_chg", 32'(seg_chg), 32'({S0, S0}));
    chk_val("t7_rst_vend", 32'(vend), 32'd0);
    chk_val("t7_rst_fault", 32'(fault), 32'd0);
    chk_val("t7_rst_litup", 32'(litup), 32'd0);
    chk_state("t7_rst_state", IDLE);
    cycles(3);
    rst_n = 1'b1;
    cycles(DEB + 20);
    chk_val("t7_held_key_silent", 32'(seg_item), 32'({S0, S0}));
    sel_key = 1'b1;
    cycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
